vga_rx_timing: RTL and testbench
================================

Name: vga_rx_timing

Overview:
Receive-side counterpart of the VGA sync generator. Samples hsync/vsync/rgb at pixel rate and locks onto 640x480@60 timing (800x525 total). Recovers pixel coordinates, a display-enable and a frame strobe. Used as an on-chip loopback checker and bench monitor for the renderer output, and reports timing violations through a saturating error counter.

Parameters:
H_TOTAL, 800, pixel ticks per line
V_TOTAL, 525, lines per frame
H_DISPLAY, 640, active pixels per line
V_DISPLAY, 480, active lines per frame
H_SYNC_POS, 656, h coordinate of the first sampled hsync=1
V_SYNC_POS, 513, v coordinate of the first sampled vsync=1
SYNC_ACTIVE, 1, sync polarity (1 = high during retrace, matching the generator)
LOCK_LINES, 2, consecutive correct hsync periods needed for horizontal lock

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high
pix_en  in  1  pixel tick; inputs are sampled only when 1
hsync  in  1  horizontal sync from the transmitter
vsync  in  1  vertical sync from the transmitter
rgb_in  in  12  pixel colour {R4,G4,B4}
x  out  10  recovered horizontal coordinate
y  out  10  recovered vertical coordinate
de  out  1  1 when locked and x<H_DISPLAY and y<V_DISPLAY
rgb_out  out  12  rgb_in registered, forced to 0 when de=0
pix_valid  out  1  one-clk pulse per sampled pixel while locked
frame_start  out  1  one-clk pulse when (x,y) becomes (0,0) while locked
locked  out  1  1 in state LOCKED
err_count  out  8  timing violations, saturating at 255

Behaviour:
- Reset: all outputs 0, state SEARCH, internal h/v counters 0, previous-sync registers 0.
- Sync normalisation: hs = hsync XNOR SYNC_ACTIVE and vs likewise. Edges are detected only between consecutive pix_en samples. Nothing changes on clocks where pix_en=0.
- Counters advance on pix_en: h wraps at H_TOTAL-1 to 0. v increments on the h wrap and wraps at V_TOTAL-1 to 0.
- hs rising edge: h is loaded with H_SYNC_POS (SEARCH, H_LOCK) or checked against it (LOCKED).
- vs rising edge: v is loaded with V_SYNC_POS (H_LOCK) or checked against it (LOCKED).
- FSM:
  - SEARCH: on hs rising edge, load h, line_ok=0, go to H_LOCK.
  - H_LOCK: each hs rising edge with the pre-load h == H_SYNC_POS increments line_ok. Otherwise line_ok=0 and h is reloaded. When line_ok==LOCK_LINES and a vs rising edge occurs, load v=V_SYNC_POS, go to LOCKED.
  - LOCKED: hs rising edge with h!=H_SYNC_POS, or vs rising edge with v!=V_SYNC_POS or h!=H_SYNC_POS, is a violation: err_count+1 (saturating), go to SEARCH. hs held for more than 96 samples is also a violation.
- Simultaneous hs and vs rising edges on the same sample are legal (normal timing); both checks apply on that sample.
- Outputs are registered, with latency 1 clk after the sampling pix_en clock. x/y reflect the counter value assigned to that sample. Leaving LOCKED deasserts de and locked on the next clk.
- err_count is only cleared by reset. A violation at 255 leaves it at 255.
- Reset mid-frame: return to SEARCH; relock requires LOCK_LINES lines plus a vsync edge.

Decomposition:
- Shared package vga_timing_pkg: H_*/V_* constants, shared with vga_sync, plus the FSM state encoding (SEARCH=0, H_LOCK=1, LOCKED=2).
- One natural sub-module: vga_sync_edge, which holds the per-signal sample register, the pix_en-qualified rising-edge detector and the high-duration counter. It is instantiated for hsync and for vsync.

Test Plan:
- vga_sync instance driving inputs (pix_en=p_tick, rgb_in=x[3:0] replicated), after reset -> locked=1 by the first vsync following 2 lines; then x/y match the generator delayed 1 clk; err_count=0 over 3 frames.
- Locked, rgb_in=12'hFFF constant -> rgb_out=FFF for exactly 640x480 samples per frame, 0 elsewhere; frame_start pulses once per 420000 samples.
- Inject one hsync rising edge 10 pixels early in LOCKED -> err_count=1, locked=0 next clk, relock within the following frame.
- Drive 255+3 violations -> err_count stays 255.
- Hold hsync high for 200 samples -> violation counted, locked drops; with SYNC_ACTIVE=0 and inverted syncs the lock time is identical to scenario 1.
- Assert reset mid-line at x=300,y=200 -> all outputs 0 next clk, state SEARCH; locked=0 until the lock sequence completes again.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480@60 timing constants and receiver state encoding
package vga_timing_pkg;

    localparam int H_TOTAL    = 800;
    localparam int V_TOTAL    = 525;
    localparam int H_DISPLAY  = 640;
    localparam int V_DISPLAY  = 480;
    localparam int H_SYNC_POS = 656;
    localparam int V_SYNC_POS = 513;
    localparam int H_SYNC_LEN = 96;
    localparam int LOCK_LINES = 2;
    localparam bit SYNC_ACTIVE = 1'b1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        H_LOCK = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    function automatic logic [9:0] wrap_inc(input logic [9:0] val, input logic [9:0] last);
        return (val == last) ? 10'd0 : val + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - pix_en-qualified sync sampler with rising-edge and over-length detect
module vga_sync_edge #(
    parameter bit ACTIVE   = 1'b1,
    parameter int MAX_HIGH = 96
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic sync_in,
    output logic rise,
    output logic long_high
);

    logic       level;
    logic       prev;
    logic [7:0] high_cnt;

    assign level = ~(sync_in ^ ACTIVE);
    assign rise  = pix_en & level & ~prev;
    // high_cnt counts earlier high samples, so this fires on sample MAX_HIGH+1
    assign long_high = pix_en & level & (high_cnt == 8'(MAX_HIGH));

    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= 1'b0;
            high_cnt <= '0;
        end else if (pix_en) begin
            prev <= level;
            if (!level) begin
                high_cnt <= '0;
            end else if (high_cnt != 8'hFF) begin
                high_cnt <= high_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/vga_rx_timing.sv
// rtl/vga_rx_timing.sv - VGA receive-side timing lock, coordinate recovery and violation counter
module vga_rx_timing #(
    parameter int H_TOTAL    = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL    = vga_timing_pkg::V_TOTAL,
    parameter int H_DISPLAY  = vga_timing_pkg::H_DISPLAY,
    parameter int V_DISPLAY  = vga_timing_pkg::V_DISPLAY,
    parameter int H_SYNC_POS = vga_timing_pkg::H_SYNC_POS,
    parameter int V_SYNC_POS = vga_timing_pkg::V_SYNC_POS,
    parameter int H_SYNC_LEN = vga_timing_pkg::H_SYNC_LEN,
    parameter int LOCK_LINES = vga_timing_pkg::LOCK_LINES,
    parameter bit SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic [11:0] rgb_out,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_count
);

    import vga_timing_pkg::*;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP = 10'(V_DISPLAY);
    localparam logic [9:0] H_POS  = 10'(H_SYNC_POS);
    localparam logic [9:0] V_POS  = 10'(V_SYNC_POS);
    localparam logic [3:0] LOCK_N = 4'(LOCK_LINES);

    rx_state_t  state, state_nx;
    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_cur, v_cur;
    logic [9:0] h_nx, v_nx;
    logic [3:0] line_ok, line_ok_nx;
    logic       hs_rise, hs_long;
    logic       vs_rise, vs_long_unused;
    logic       violation;
    logic       lock_nx;
    logic       de_nx;

    vga_sync_edge #(.ACTIVE(SYNC_ACTIVE), .MAX_HIGH(H_SYNC_LEN)) u_hs_edge (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .sync_in   (hsync),
        .rise      (hs_rise),
        .long_high (hs_long)
    );

    vga_sync_edge #(.ACTIVE(SYNC_ACTIVE), .MAX_HIGH(H_SYNC_LEN)) u_vs_edge (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .sync_in   (vsync),
        .rise      (vs_rise),
        .long_high (vs_long_unused)
    );

    // h_cnt/v_cnt hold the coordinate predicted for the current sample; h_cur/v_cur
    // is what the sample is finally assigned after any sync-edge load.
    always_comb begin
        state_nx   = state;
        line_ok_nx = line_ok;
        h_cur      = h_cnt;
        v_cur      = v_cnt;
        violation  = 1'b0;
        case (state)
            SEARCH: begin
                if (hs_rise) begin
                    h_cur      = H_POS;
                    line_ok_nx = '0;
                    state_nx   = H_LOCK;
                end
            end
            H_LOCK: begin
                if (hs_rise) begin
                    h_cur = H_POS;
                    if (h_cnt == H_POS) begin
                        line_ok_nx = (line_ok == LOCK_N) ? line_ok : line_ok + 4'd1;
                    end else begin
                        line_ok_nx = '0;
                    end
                end
                if (vs_rise) begin
                    v_cur = V_POS;
                    if (line_ok_nx == LOCK_N) begin
                        state_nx = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if ((hs_rise && h_cnt != H_POS) ||
                    (vs_rise && (v_cnt != V_POS || h_cnt != H_POS)) ||
                    hs_long) begin
                    violation = 1'b1;
                    state_nx  = SEARCH;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    assign h_nx    = wrap_inc(h_cur, H_LAST);
    assign v_nx    = (h_cur == H_LAST) ? wrap_inc(v_cur, V_LAST) : v_cur;
    assign lock_nx = (state_nx == LOCKED);
    assign de_nx   = lock_nx && (h_cur < H_DISP) && (v_cur < V_DISP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_ok     <= '0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            rgb_out     <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                state       <= state_nx;
                h_cnt       <= h_nx;
                v_cnt       <= v_nx;
                line_ok     <= line_ok_nx;
                x           <= h_cur;
                y           <= v_cur;
                de          <= de_nx;
                rgb_out     <= de_nx ? rgb_in : 12'h000;
                pix_valid   <= lock_nx;
                frame_start <= lock_nx && (h_cur == 10'd0) && (v_cur == 10'd0);
                locked      <= lock_nx;
                if (violation && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_timing.sv
// tb/tb_vga_rx_timing.sv - randomized self-checking bench for vga_rx_timing on a reduced raster
module tb_vga_rx_timing;

    localparam int HT = 12, VT = 6, HD = 8, VD = 4, HSP = 9, VSP = 5, HSL = 2, LL = 2;
    localparam int FRAME = HT * VT;
    localparam int VS_START = VSP * HT + HSP;

    logic clk = 1'b0;
    logic reset = 1'b1, pix_en = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [11:0] rgb_in = '0;
    logic hsync_n, vsync_n;
    logic [9:0] x, y, x_n, y_n;
    logic de, pix_valid, frame_start, locked, de_n, pix_valid_n, frame_start_n, locked_n;
    logic [11:0] rgb_out, rgb_out_n;
    logic [7:0] err_count, err_count_n;
    logic [43:0] d_vec, d_vec_n, e_vec;

    assign hsync_n = ~hsync;
    assign vsync_n = ~vsync;
    assign d_vec   = {x, y, de, rgb_out, pix_valid, frame_start, locked, err_count};
    assign d_vec_n = {x_n, y_n, de_n, rgb_out_n, pix_valid_n, frame_start_n, locked_n, err_count_n};

    always #5 clk = ~clk;

    vga_rx_timing #(.H_TOTAL(HT), .V_TOTAL(VT), .H_DISPLAY(HD), .V_DISPLAY(VD),
        .H_SYNC_POS(HSP), .V_SYNC_POS(VSP), .H_SYNC_LEN(HSL), .LOCK_LINES(LL),
        .SYNC_ACTIVE(1'b1)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .rgb_in(rgb_in), .x(x), .y(y), .de(de), .rgb_out(rgb_out),
        .pix_valid(pix_valid), .frame_start(frame_start), .locked(locked),
        .err_count(err_count));

    vga_rx_timing #(.H_TOTAL(HT), .V_TOTAL(VT), .H_DISPLAY(HD), .V_DISPLAY(VD),
        .H_SYNC_POS(HSP), .V_SYNC_POS(VSP), .H_SYNC_LEN(HSL), .LOCK_LINES(LL),
        .SYNC_ACTIVE(1'b0)) dut_n (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync_n), .vsync(vsync_n),
        .rgb_in(rgb_in), .x(x_n), .y(y_n), .de(de_n), .rgb_out(rgb_out_n),
        .pix_valid(pix_valid_n), .frame_start(frame_start_n), .locked(locked_n),
        .err_count(err_count_n));

    int n_checks = 0, n_fail = 0, n_viol = 0;
    // reference model: mode 0 searching, 1 counting good lines, 2 locked
    int m_mode, m_h, m_v, m_line, m_err, m_run;
    bit m_phs, m_pvs;
    int e_x, e_y;
    bit e_de, e_pv, e_fs, e_lk;
    logic [11:0] e_rgb;
    // generator state
    int gp = 0, hold_req = 0, hold_left = 0, last_p = 0;
    bit inj_early = 0, rgb_fff = 0, last_pe = 0;

    function automatic logic [43:0] pack_exp();
        return {10'(e_x), 10'(e_y), e_de, e_rgb, e_pv, e_fs, e_lk, 8'(m_err)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_h = 0; m_v = 0; m_line = 0; m_err = 0; m_run = 0;
        m_phs = 0; m_pvs = 0;
        e_x = 0; e_y = 0; e_de = 0; e_pv = 0; e_fs = 0; e_lk = 0; e_rgb = '0;
        e_vec = pack_exp();
    endtask

    task automatic model_step(input bit pe, input bit hs, input bit vs, input logic [11:0] rgb);
        bit hr, vr, bad;
        int cx, cy, lin;
        if (!pe) begin
            e_pv = 0; e_fs = 0; e_vec = pack_exp();
            return;
        end
        hr = hs && !m_phs;
        vr = vs && !m_pvs;
        m_run = hs ? m_run + 1 : 0;
        m_phs = hs; m_pvs = vs;
        cx = m_h; cy = m_v;
        if (m_mode == 0) begin
            if (hr) begin cx = HSP; m_line = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (hr) begin
                m_line = (m_h == HSP) ? ((m_line < LL) ? m_line + 1 : LL) : 0;
                cx = HSP;
            end
            if (vr) begin
                cy = VSP;
                if (m_line == LL) m_mode = 2;
            end
        end else begin
            bad = (hr && m_h != HSP) || (vr && (m_v != VSP || m_h != HSP)) || (m_run == HSL + 1);
            if (bad) begin
                m_mode = 0;
                if (m_err < 255) m_err++;
            end
        end
        lin = (cy * HT + cx + 1) % FRAME;
        m_h = lin % HT; m_v = lin / HT;
        e_lk = (m_mode == 2);
        e_x = cx; e_y = cy;
        e_de = e_lk && cx < HD && cy < VD;
        e_rgb = e_de ? rgb : 12'h000;
        e_pv = e_lk;
        e_fs = e_lk && cx == 0 && cy == 0;
        e_vec = pack_exp();
    endtask

    task automatic drive(input bit pe, input bit hs, input bit vs, input logic [11:0] rgb);
        @(negedge clk);
        pix_en = pe; hsync = hs; vsync = vs; rgb_in = rgb;
        model_step(pe, hs, vs, rgb);
        @(posedge clk);
        #1;
    endtask

    // one clock of stimulus: random pix_en gaps carry garbage syncs
    task automatic gen_step();
        bit hs, vs;
        int h;
        if ($urandom_range(0, 3) == 0) begin
            last_pe = 0;
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom));
            return;
        end
        h = gp % HT;
        hs = (h >= HSP && h < HSP + HSL);
        if (h == HSP && hold_req > 0) begin hold_left = hold_req; hold_req = 0; end
        if (hold_left > 0) begin hs = 1; hold_left--; end
        if (inj_early && h == HSP - 3) begin hs = 1; inj_early = 0; end
        vs = (((gp - VS_START) + FRAME) % FRAME) < HT;
        last_p = gp; last_pe = 1;
        drive(1, hs, vs, rgb_fff ? 12'hFFF : 12'($urandom));
        gp = (gp + 1) % FRAME;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; pix_en = 1; hsync = 1; vsync = 1; rgb_in = 12'hABC;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (d_vec !== 44'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", d_vec); end
        n_checks++;
        if (d_vec_n !== 44'h0) begin n_fail++; $display("FAIL reset_outputs_inv: got %h want 0", d_vec_n); end
        @(negedge clk);
        reset = 0; pix_en = 0; hsync = 0; vsync = 0;
        model_reset();
    endtask

    task automatic test_lock();
        int cyc, samples, n_fff, n_fs;
        gp = $urandom_range(0, FRAME - 1);
        cyc = 0;
        while (!e_lk && cyc < 6 * FRAME) begin
            gen_step(); cyc++;
            n_checks++;
            if (d_vec !== e_vec || d_vec_n !== e_vec) begin
                n_fail++; if (n_fail < 50) $display("FAIL lock_acquire: got %h inv %h want %h", d_vec, d_vec_n, e_vec);
            end
        end
        n_checks++;
        if (locked !== 1'b1 || locked_n !== 1'b1 || last_p != VS_START) begin
            n_fail++; $display("FAIL lock_point: locked=%0b inv=%0b at p=%0d want 1 at p=%0d", locked, locked_n, last_p, VS_START);
        end
        samples = 0; cyc = 0;
        while (samples < 3 * FRAME && cyc < 8 * FRAME) begin
            gen_step(); cyc++;
            n_checks++;
            if (d_vec !== e_vec || d_vec_n !== e_vec) begin
                n_fail++; if (n_fail < 50) $display("FAIL track: got %h inv %h want %h", d_vec, d_vec_n, e_vec);
            end
            if (last_pe) begin
                samples++;
                n_checks++;
                if (x != last_p % HT || y != last_p / HT) begin
                    n_fail++; if (n_fail < 50) $display("FAIL coord: got %0d,%0d want %0d,%0d", x, y, last_p % HT, last_p / HT);
                end
            end
        end
        n_checks++;
        if (err_count !== 8'd0 || locked !== 1'b1) begin
            n_fail++; $display("FAIL clean_frames: err=%0d locked=%0b want 0/1", err_count, locked);
        end
        rgb_fff = 1; cyc = 0;
        while (gp != 0 && cyc < 4 * FRAME) begin gen_step(); cyc++; end
        samples = 0; n_fff = 0; n_fs = 0; cyc = 0;
        while (samples < 3 * FRAME && cyc < 8 * FRAME) begin
            gen_step(); cyc++;
            n_checks++;
            if (d_vec !== e_vec || d_vec_n !== e_vec) begin
                n_fail++; if (n_fail < 50) $display("FAIL white: got %h inv %h want %h", d_vec, d_vec_n, e_vec);
            end
            if (last_pe) begin
                samples++;
                if (rgb_out == 12'hFFF) n_fff++;
                if (frame_start) n_fs++;
            end
        end
        rgb_fff = 0;
        n_checks++;
        if (n_fff != 3 * HD * VD) begin n_fail++; $display("FAIL white_count: got %0d want %0d", n_fff, 3 * HD * VD); end
        n_checks++;
        if (n_fs != 3) begin n_fail++; $display("FAIL frame_start_count: got %0d want 3", n_fs); end
    endtask

    task automatic test_early_hs();
        int cyc, samples;
        inj_early = 1; cyc = 0;
        while (inj_early && cyc < 4 * FRAME) begin
            gen_step(); cyc++;
            n_checks++;
            if (d_vec !== e_vec || d_vec_n !== e_vec) begin
                n_fail++; if (n_fail < 50) $display("FAIL early_wait: got %h inv %h want %h", d_vec, d_vec_n, e_vec);
            end
        end
        n_viol++;
        n_checks++;
        if (locked !== 1'b0 || err_count !== 8'(n_viol) || err_count_n !== 8'(n_viol)) begin
            n_fail++; $display("FAIL early_violation: locked=%0b err=%0d inv_err=%0d want 0/%0d", locked, err_count, err_count_n, n_viol);
        end
        samples = 0; cyc = 0;
        while (!e_lk && cyc < 4 * FRAME) begin
            gen_step(); cyc++;
            if (last_pe) samples++;
            n_checks++;
            if (d_vec !== e_vec || d_vec_n !== e_vec) begin
                n_fail++; if (n_fail < 50) $display("FAIL early_relock: got %h inv %h want %h", d_vec, d_vec_n, e_vec);
            end
        end
        n_checks++;
        if (locked !== 1'b1 || samples > FRAME) begin
            n_fail++; $display("FAIL early_relock_time: locked=%0b after %0d samples want 1 within %0d", locked, samples, FRAME);
        end
    endtask

    task automatic test_long_hs();
        int cyc;
        hold_req = 6; cyc = 0;
        while (e_lk && cyc < 4 * FRAME) begin
            gen_step(); cyc++;
            n_checks++;
            if (d_vec !== e_vec || d_vec_n !== e_vec) begin
                n_fail++; if (n_fail < 50) $display("FAIL long_wait: got %h inv %h want %h", d_vec, d_vec_n, e_vec);
            end
        end
        n_viol++;
        n_checks++;
        if (locked !== 1'b0 || err_count !== 8'(n_viol) || last_p % HT != HSP + HSL) begin
            n_fail++; $display("FAIL long_violation: locked=%0b err=%0d at h=%0d want 0/%0d at h=%0d", locked, err_count, last_p % HT, n_viol, HSP + HSL);
        end
        cyc = 0;
        while (!e_lk && cyc < 4 * FRAME) begin
            gen_step(); cyc++;
            n_checks++;
            if (d_vec !== e_vec || d_vec_n !== e_vec) begin
                n_fail++; if (n_fail < 50) $display("FAIL long_relock: got %h inv %h want %h", d_vec, d_vec_n, e_vec);
            end
        end
        n_checks++;
        if (locked !== 1'b1 || locked_n !== 1'b1) begin
            n_fail++; $display("FAIL long_relock_done: locked=%0b inv=%0b want 1", locked, locked_n);
        end
    endtask

    task automatic test_mid_reset();
        int cyc, samples;
        cyc = 0;
        while (!(gp == 2 * HT + 5 && e_lk) && cyc < 4 * FRAME) begin gen_step(); cyc++; end
        @(negedge clk);
        reset = 1; pix_en = 1; rgb_in = 12'h5A5;
        @(posedge clk);
        #1;
        model_reset();
        n_viol = 0;
        n_checks++;
        if (d_vec !== 44'h0 || d_vec_n !== 44'h0) begin
            n_fail++; $display("FAIL mid_reset: got %h inv %h want 0", d_vec, d_vec_n);
        end
        @(negedge clk);
        reset = 0; pix_en = 0;
        samples = 0; cyc = 0;
        while (!e_lk && cyc < 4 * FRAME) begin
            gen_step(); cyc++;
            if (last_pe) samples++;
            n_checks++;
            if (d_vec !== e_vec || d_vec_n !== e_vec) begin
                n_fail++; if (n_fail < 50) $display("FAIL mid_reset_relock: got %h inv %h want %h", d_vec, d_vec_n, e_vec);
            end
        end
        n_checks++;
        if (locked !== 1'b1 || samples <= LL * HT || last_p != VS_START) begin
            n_fail++; $display("FAIL mid_reset_lock: locked=%0b after %0d samples at p=%0d want 1 at p=%0d", locked, samples, last_p, VS_START);
        end
    endtask

    task automatic test_saturate();
        int cyc;
        bit stuck;
        stuck = 0;
        for (int i = 0; i < 258 && !stuck; i++) begin
            cyc = 0;
            while (!e_lk && cyc < 4 * FRAME) begin
                gen_step(); cyc++;
                n_checks++;
                if (d_vec !== e_vec || d_vec_n !== e_vec) begin
                    n_fail++; if (n_fail < 50) $display("FAIL sat_relock: got %h inv %h want %h", d_vec, d_vec_n, e_vec);
                end
            end
            if (!e_lk) begin
                stuck = 1; n_checks++; n_fail++;
                $display("FAIL sat_relock_timeout: locked=%0b want 1", locked);
            end else begin
                inj_early = 1; cyc = 0;
                while (inj_early && cyc < 4 * FRAME) begin
                    gen_step(); cyc++;
                    n_checks++;
                    if (d_vec !== e_vec || d_vec_n !== e_vec) begin
                        n_fail++; if (n_fail < 50) $display("FAIL sat_inject: got %h inv %h want %h", d_vec, d_vec_n, e_vec);
                    end
                end
                n_viol++;
            end
        end
        n_checks++;
        if (err_count !== 8'd255 || err_count_n !== 8'd255 || n_viol < 256) begin
            n_fail++; $display("FAIL saturate: err=%0d inv=%0d after %0d violations want 255", err_count, err_count_n, n_viol);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_early_hs();
        test_long_hs();
        test_mid_reset();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
